// File: rtl/seg_scan_ctrl_if.sv
// Display-update handshake between the CPU-side display register and the scan controller.
// The requester holds upd high until it sees upd_ack.
interface seg_scan_ctrl_if;
    logic        upd;
    logic [31:0] upd_data;
    logic [7:0]  upd_mask;
    logic [7:0]  upd_dp;
    logic        upd_ack;

    modport master (output upd, upd_data, upd_mask, upd_dp, input upd_ack);
    modport slave  (input upd, upd_data, upd_mask, upd_dp, output upd_ack);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scans an 8-digit multiplexed 7-segment display with a blanking guard between digits.
// Display contents are double-buffered and swap only at the digit 7 -> digit 0 frame boundary.
module seg_scan_ctrl #(
    parameter logic [17:0] SCAN_CNT_END = 18'd199_999,
    parameter logic [7:0]  GUARD_CYC    = 8'd50
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    seg_scan_ctrl_if.slave   upd_if,
    output logic [7:0]       led_en,
    output logic [7:0]       led_seg
);

    localparam int unsigned CNT_W  = 18;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DIG_N  = 8;
    localparam int unsigned DATA_W = 32;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC) - CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIG_N - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DRIVE,
        ST_BLANK
    } state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [DATA_W-1:0]  data_q, data_nxt;
    logic [DIG_N-1:0]   mask_q, mask_nxt;
    logic [DIG_N-1:0]   dp_q, dp_nxt;
    logic [7:0]         led_en_q, led_en_nxt;
    logic [7:0]         led_seg_q, led_seg_nxt;
    logic               ack_q, ack_nxt;
    logic               load;
    logic [6:0]         digit_seg;

    // Active-high {g,f,e,d,c,b,a} glyph for one hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Next state, counters, shadow load and the pin values for the upcoming cycle
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        idx_nxt     = idx_q;
        data_nxt    = data_q;
        mask_nxt    = mask_q;
        dp_nxt      = dp_q;
        ack_nxt     = 1'b0;
        load        = 1'b0;
        led_en_nxt  = 8'hFF;
        led_seg_nxt = 8'hFF;
        digit_seg   = 7'h00;

        case (state_q)
            ST_OFF: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                load    = upd_if.upd;
                if (en) begin
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SCAN_CNT_END) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_BLANK: begin
                if (cnt_q == GUARD_LAST) begin
                    state_nxt = ST_DRIVE;
                    cnt_nxt   = '0;
                    idx_nxt   = idx_q + IDX_W'(1);
                    // Frame boundary: the only point a scanning display takes new data
                    load      = upd_if.upd && (idx_q == IDX_LAST);
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_OFF;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase

        // Disable wins; a request pending here is picked up once parked in OFF
        if (!en) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            if (state_q != ST_OFF) begin
                load = 1'b0;
            end
        end

        if (load) begin
            data_nxt = upd_if.upd_data;
            mask_nxt = upd_if.upd_mask;
            dp_nxt   = upd_if.upd_dp;
            ack_nxt  = 1'b1;
        end

        // Pins follow the next state so the first DRIVE cycle already shows the digit
        digit_seg = hex7(data_nxt[{idx_nxt, 2'b00} +: 4]);
        if (state_nxt == ST_DRIVE) begin
            led_en_nxt = ~(8'(1) << idx_nxt);
            if (mask_nxt[idx_nxt]) begin
                led_seg_nxt = ~{dp_nxt[idx_nxt], digit_seg};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            dp_q      <= '0;
            led_en_q  <= 8'hFF;
            led_seg_q <= 8'hFF;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            idx_q     <= idx_nxt;
            data_q    <= data_nxt;
            mask_q    <= mask_nxt;
            dp_q      <= dp_nxt;
            led_en_q  <= led_en_nxt;
            led_seg_q <= led_seg_nxt;
            ack_q     <= ack_nxt;
        end
    end

    assign led_en         = led_en_q;
    assign led_seg        = led_seg_q;
    assign upd_if.upd_ack = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short scan (10 drive + 2 guard cycles per digit).
// Observed value per cycle is {upd_ack, led_en, led_seg}.
module tb_seg_scan_ctrl;

    localparam logic [17:0] SCAN_END = 18'd9;
    localparam logic [7:0]  GUARD    = 8'd2;
    localparam int          DRV      = 10;
    localparam int          SLOT     = 12;
    localparam int          FRAME    = 96;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] led_en;
    logic [7:0] led_seg;

    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(
        .SCAN_CNT_END (SCAN_END),
        .GUARD_CYC    (GUARD)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .upd_if  (bus),
        .led_en  (led_en),
        .led_seg (led_seg)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  mask;
        logic [7:0]  dp;
        logic [63:0] segs;   // expected led_seg of digit k at [8k +: 8]
        string       name;
    } vec_t;

    vec_t vecs[4];

    localparam logic [63:0] SEGS_R0  = 64'hF8_82_92_99_B0_A4_F9_C0;
    localparam logic [63:0] SEGS_ALL8 = 64'h80_80_80_80_80_80_80_80;
    localparam logic [63:0] SEGS_DARK = 64'hFF_FF_FF_FF_FF_FF_FF_FF;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [16:0] obs();
        return {bus.upd_ack, led_en, led_seg};
    endfunction

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: ack/en/seg got %05h want %05h", name, got, exp);
        end
    endtask

    // Expected pins s cycles after scanning starts (s=1 is the first drive cycle of digit 0)
    function automatic logic [16:0] frame_exp(input int s, input logic [63:0] segs, input logic ack);
        int d;
        int c;
        logic [7:0] sel;
        d   = ((s - 1) / SLOT) % 8;
        c   = (s - 1) % SLOT;
        sel = ~(8'b1 << d);
        if (c < DRV) return {ack, sel, segs[8*d +: 8]};
        return {ack, 16'hFFFF};
    endfunction

    // Update handshake while parked in OFF: ack one cycle later, then a single pulse
    task automatic load_off(input logic [31:0] d, input logic [7:0] m, input logic [7:0] p);
        bus.upd      = 1'b1;
        bus.upd_data = d;
        bus.upd_mask = m;
        bus.upd_dp   = p;
        step();
        check("upd_ack_off", obs(), {1'b1, 16'hFFFF});
        bus.upd = 1'b0;
        step();
        check("upd_ack_single", obs(), {1'b0, 16'hFFFF});
    endtask

    initial begin
        vecs[0] = '{32'h76543210, 8'hFF, 8'h00, SEGS_R0, "hex0_7"};
        vecs[1] = '{32'hFEDCBA98, 8'hFF, 8'h00, 64'h8E_86_A1_C6_83_88_90_80, "hex8_F"};
        vecs[2] = '{32'h00000000, 8'h0F, 8'h01, 64'hFF_FF_FF_FF_C0_C0_C0_40, "mask0F_dp01"};
        vecs[3] = '{32'h12345678, 8'hA5, 8'hF0, 64'h79_FF_30_FF_FF_82_FF_80, "maskA5_dpF0"};

        rst          = 1'b1;
        en           = 1'b0;
        bus.upd      = 1'b0;
        bus.upd_data = '0;
        bus.upd_mask = '0;
        bus.upd_dp   = '0;
        step();
        step();
        check("reset_state", obs(), {1'b0, 16'hFFFF});
        rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            step();
            check($sformatf("idle_c%0d", i), obs(), {1'b0, 16'hFFFF});
        end

        // Table: load in OFF, scan one full frame plus the first cycle of the next
        for (int i = 0; i < 4; i++) begin
            load_off(vecs[i].data, vecs[i].mask, vecs[i].dp);
            en = 1'b1;
            for (int s = 1; s <= FRAME + 1; s++) begin
                step();
                check($sformatf("%s_s%0d", vecs[i].name, s), obs(), frame_exp(s, vecs[i].segs, 1'b0));
            end
            en = 1'b0;
            step();
            check($sformatf("%s_off", vecs[i].name), obs(), {1'b0, 16'hFFFF});
        end

        // Update raised mid digit 3 waits for the frame wrap
        load_off(32'h76543210, 8'hFF, 8'h00);
        en = 1'b1;
        for (int s = 1; s <= 37; s++) begin
            step();
            check($sformatf("pre_upd_s%0d", s), obs(), frame_exp(s, SEGS_R0, 1'b0));
        end
        bus.upd      = 1'b1;
        bus.upd_data = 32'h88888888;
        bus.upd_mask = 8'hFF;
        bus.upd_dp   = 8'h00;
        for (int s = 38; s <= FRAME; s++) begin
            step();
            check($sformatf("pending_s%0d", s), obs(), frame_exp(s, SEGS_R0, 1'b0));
        end
        step();
        check("wrap_ack_and_new_digit0", obs(), {1'b1, 8'hFE, 8'h80});
        bus.upd = 1'b0;
        for (int s = FRAME + 2; s <= 160; s++) begin
            step();
            check($sformatf("new_data_s%0d", s), obs(), frame_exp(s, SEGS_ALL8, 1'b0));
        end

        // en drops mid digit 5, then a full restart at digit 0
        en = 1'b0;
        step();
        check("en_drop", obs(), {1'b0, 16'hFFFF});
        step();
        check("en_drop_hold", obs(), {1'b0, 16'hFFFF});
        en = 1'b1;
        for (int s = 1; s <= 23; s++) begin
            step();
            check($sformatf("restart_s%0d", s), obs(), frame_exp(s, SEGS_ALL8, 1'b0));
        end

        // Reset in the digit 1 guard with a request pending: no ack, shadow cleared
        bus.upd      = 1'b1;
        bus.upd_data = 32'h12345678;
        bus.upd_mask = 8'hFF;
        bus.upd_dp   = 8'hFF;
        rst          = 1'b1;
        step();
        check("rst_mid_blank", obs(), {1'b0, 16'hFFFF});
        rst     = 1'b0;
        bus.upd = 1'b0;
        for (int s = 1; s <= 25; s++) begin
            step();
            check($sformatf("post_rst_s%0d", s), obs(), frame_exp(s, SEGS_DARK, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
